// File: rtl/scan_pkg.sv
// Shared definitions for the word-based 10011 scan controller.
package scan_pkg;

    localparam int PATTERN_LEN = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3,
        CLEAR = 3'd4
    } state_t;

endpackage

// File: rtl/scan_serializer.sv
// MSB-first word serializer; bit_out is registered and last_bit rises once the final bit is out.
module scan_serializer #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic              bit_out,
    output logic              last_bit
);

    localparam int BC_W = $clog2(WORD_W);

    logic [WORD_W-1:0] shreg;
    logic [BC_W-1:0]   bit_cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= word;
        end else if (shift) begin
            shreg <= {shreg[WORD_W-2:0], 1'b0};
        end
    end

    // Once all bits are out, further shifts emit the zero fill, keeping the stream low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt  <= '0;
            bit_out  <= 1'b0;
            last_bit <= 1'b0;
        end else if (load) begin
            bit_cnt  <= BC_W'(WORD_W - 1);
            bit_out  <= 1'b0;
            last_bit <= 1'b0;
        end else if (shift) begin
            bit_out  <= shreg[WORD_W-1];
            last_bit <= (bit_cnt == '0);
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sequence_detector.sv
// Non-overlapping 10011 detector; the bit presented while detected=1 is ignored.
module sequence_detector (
    input  logic clk,
    input  logic reset,
    input  logic stream,
    output logic detected
);

    typedef enum logic [2:0] {S0, S1, S10, S100, S1001, SDET} det_state_t;

    det_state_t st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st <= S0;
        end else begin
            case (st)
                S0:      st <= stream ? S1    : S0;
                S1:      st <= stream ? S1    : S10;
                S10:     st <= stream ? S1    : S100;
                S100:    st <= stream ? S1001 : S0;
                S1001:   st <= stream ? SDET  : S10;
                SDET:    st <= S0;
                default: st <= S0;
            endcase
        end
    end

    assign detected = (st == SDET);

endmodule

// File: rtl/stream_scan_ctrl.sv
// Feeds words bit-serially to a 10011 detector and reports per-word and running hit counts.
module stream_scan_ctrl
    import scan_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 5,
    parameter int TOT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  out_hits,
    output logic [TOT_W-1:0]  total_hits,
    input  logic              clr_total,
    output logic              det_stream,
    output logic              det_reset,
    input  logic              det_hit
);

    localparam int SUM_W = TOT_W + 1;

    state_t state;
    logic   load;
    logic   shift;
    logic   last_bit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TOT_W-1:0] sat_add(input logic [TOT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = {1'b0, a} + SUM_W'(b);
        return s[TOT_W] ? '1 : s[TOT_W-1:0];
    endfunction

    assign load  = (state == IDLE) && in_valid;
    assign shift = (state == SHIFT);

    scan_serializer #(.WORD_W(WORD_W)) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .word     (in_word),
        .bit_out  (det_stream),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_hits   <= '0;
            total_hits <= '0;
            det_reset  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    out_hits  <= '0;
                    det_reset <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (det_hit) out_hits <= sat_inc(out_hits);
                    if (last_bit) state <= DRAIN;
                end
                // The detector answers one cycle late, so the final bit's hit lands here.
                DRAIN: begin
                    if (det_hit) out_hits <= sat_inc(out_hits);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        total_hits <= sat_add(total_hits, out_hits);
                        det_reset  <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                default: begin
                    det_reset <= 1'b1;
                    state     <= CLEAR;
                end
            endcase
            if (clr_total) total_hits <= '0;
        end
    end

    // Each hit consumes a full pattern, bounding the per-word count.
    always_ff @(posedge clk) begin
        if (!reset && state == DONE) begin
            assert (int'(out_hits) <= WORD_W / PATTERN_LEN);
        end
    end

endmodule

// File: tb/tb_stream_scan_ctrl.sv
// Directed bench: controller wired to the 10011 detector, checked with immediate assertions.
module tb_stream_scan_ctrl;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 5;
    localparam int TOT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  out_hits;
    logic [TOT_W-1:0]  total_hits;
    logic              clr_total;
    logic              det_stream;
    logic              det_reset;
    logic              det_hit;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_word    (in_word),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_hits   (out_hits),
        .total_hits (total_hits),
        .clr_total  (clr_total),
        .det_stream (det_stream),
        .det_reset  (det_reset),
        .det_hit    (det_hit)
    );

    sequence_detector u_det (
        .clk      (clk),
        .reset    (det_reset),
        .stream   (det_stream),
        .detected (det_hit)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   32'(in_ready),   0);
        check({tag, "_out_valid"},  32'(out_valid),  0);
        check({tag, "_out_hits"},   32'(out_hits),   0);
        check({tag, "_total"},      32'(total_hits), 0);
        check({tag, "_det_stream"}, 32'(det_stream), 0);
        check({tag, "_det_reset"},  32'(det_reset),  1);
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w, input int exp_hits, input string tag);
        int n;
        logic [WORD_W-1:0] seen;
        wait_ready(tag);
        in_word  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        seen = '0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
            if (n <= WORD_W) seen[WORD_W-n] = det_stream;
        end
        check({tag, "_latency"}, n, 18);
        check({tag, "_stream"},  32'(seen), 32'(w));
        check({tag, "_hits"},    32'(out_hits), exp_hits);
    endtask

    task automatic take(input logic clr);
        out_ready = 1'b1;
        clr_total = clr;
        tick();
        out_ready = 1'b0;
        clr_total = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_word   = '0;
        out_ready = 1'b0;
        clr_total = 1'b0;
        tick();
        tick();
        check_reset_values("por");

        reset = 1'b0;
        tick();
        check("clear_done_det_reset", 32'(det_reset), 0);
        check("clear_done_in_ready",  32'(in_ready),  1);

        send_word(16'h9800, 1, "w9800");
        take(1'b0);
        check("total_after_1", 32'(total_hits), 1);

        send_word(16'h9A60, 2, "w9A60");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_out_valid", 32'(out_valid),  1);
            check("bp_out_hits",  32'(out_hits),   2);
            check("bp_in_ready",  32'(in_ready),   0);
            check("bp_total",     32'(total_hits), 1);
        end
        take(1'b0);
        check("total_after_2", 32'(total_hits), 3);

        send_word(16'h9CC0, 1, "w9CC0");
        take(1'b0);
        check("total_after_3", 32'(total_hits), 4);

        send_word(16'h9800, 1, "w9800_clr");
        take(1'b1);
        check("total_clear_wins", 32'(total_hits), 0);

        send_word(16'h0009, 0, "w0009");
        take(1'b0);
        check("gap_det_reset_hi", 32'(det_reset), 1);
        tick();
        check("gap_det_reset_lo", 32'(det_reset), 0);
        check("gap_in_ready",     32'(in_ready),  1);
        send_word(16'h8000, 0, "w8000");
        take(1'b0);
        check("total_after_zeros", 32'(total_hits), 0);

        send_word(16'h9800, 1, "w9800_pre_rst");
        take(1'b0);
        check("total_pre_rst", 32'(total_hits), 1);

        wait_ready("mid");
        in_word  = 16'h9A60;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("mid_det_stream_bit7", 32'(det_stream), 1);
        check("mid_out_hits",        32'(out_hits),   1);
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        tick();
        reset = 1'b0;
        send_word(16'h9800, 1, "w9800_post_rst");
        take(1'b0);
        check("total_post_rst", 32'(total_hits), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
